// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: time-multiplexed driver for a common-anode multi-digit
// seven-segment display.
//
// Glyph codes, decimal points and digit enables are captured by `load` into a
// pending set. The pending set is copied into the display set only at the
// frame commit cycle, so the scan never shows a half-updated frame. Each digit
// gets REFRESH_DIV clocks. The first clock of every slot is a ghost-blank
// cycle that hides anode/segment switching. All pins are active-low and
// registered.
//
// Optional feature: define SSD_LZ_BLANK_EN to apply leading-zero suppression
// when a new frame is committed. With the macro undefined, no suppression
// logic is built.

module ssd_mux_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position of the cycle currently on the pins
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] idx_next;

    // Low while reset is held; the first clock after release enters slot 0 without advancing
    logic started;

    // Set by a load and cleared at the next commit
    logic commit_pending;

    // Pending register set
    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_en;

    // Display register set
    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_en;

    // Commit source and the resulting next display contents
    logic                    commit;
    logic                    take;
    logic [4*NUM_DIGITS-1:0] src_digits;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   src_en;
    logic [NUM_DIGITS-1:0]   eff_en;
    logic [4*NUM_DIGITS-1:0] disp_digits_next;
    logic [NUM_DIGITS-1:0]   disp_dp_next;
    logic [NUM_DIGITS-1:0]   disp_en_next;

    // Next values for the pin registers
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    // Active-low a..g pattern for one glyph code
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = (HEX_MODE != 0) ? 7'b0001000 : 7'b1000001;
            4'hB:    g = (HEX_MODE != 0) ? 7'b1100000 : 7'b1111111;
            4'hC:    g = (HEX_MODE != 0) ? 7'b0110001 : 7'b1111111;
            4'hD:    g = (HEX_MODE != 0) ? 7'b1000010 : 7'b1111111;
            4'hE:    g = (HEX_MODE != 0) ? 7'b0110000 : 7'b1111111;
            default: g = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111110;
        endcase
        return g;
    endfunction

`ifdef SSD_LZ_BLANK_EN
    // Clear enables of leading zeros. Walk from the top digit down. A digit
    // is dropped while it and every enabled digit above it are a plain 0
    // with no decimal point. Disabled digits do not break the run. Digit 0
    // always keeps its enable.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [4*NUM_DIGITS-1:0] d,
        input logic [NUM_DIGITS-1:0]   p,
        input logic [NUM_DIGITS-1:0]   e
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        logic                  zero;
        m   = e;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero = (d[4*i +: 4] == 4'h0) && !p[i];
            if (run && zero) begin
                m[i] = 1'b0;
            end
            if (e[i]) begin
                run = run && zero;
            end
        end
        return m;
    endfunction
`endif

    // Scan position for the next cycle: hold at slot 0 out of reset, otherwise advance
    always_comb begin
        cnt_next = cnt;
        idx_next = idx;
        if (!started) begin
            cnt_next = '0;
            idx_next = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Frame commit: a load in the commit cycle goes straight to the display set
    always_comb begin
        commit     = frame_start;
        src_digits = pend_digits;
        src_dp     = pend_dp;
        src_en     = pend_en;
        if (load) begin
            src_digits = digits_in;
            src_dp     = dp_in;
            src_en     = en_in;
        end
`ifdef SSD_LZ_BLANK_EN
        eff_en = lz_mask(src_digits, src_dp, src_en);
`else
        eff_en = src_en;
`endif
        take             = commit && (load || commit_pending);
        disp_digits_next = take ? src_digits : disp_digits;
        disp_dp_next     = take ? src_dp     : disp_dp;
        disp_en_next     = take ? eff_en     : disp_en;
    end

    // Pin values for the next cycle from the next scan position and display set
    always_comb begin
        an_next  = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if ((cnt_next != '0) && disp_en_next[idx_next]) begin
            an_next  = ~(NUM_DIGITS'(1) << idx_next);
            seg_next = glyph(disp_digits_next[4*idx_next +: 4]);
            dp_next  = ~disp_dp_next[idx_next];
        end
    end

    // Control state, enables and output pins; reset blanks the display and drops pending data
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            idx            <= '0;
            started        <= 1'b0;
            frame_start    <= 1'b0;
            commit_pending <= 1'b0;
            pend_en        <= '0;
            disp_en        <= '0;
            an             <= '1;
            seg            <= 7'b1111111;
            dp             <= 1'b1;
        end else begin
            started     <= 1'b1;
            cnt         <= cnt_next;
            idx         <= idx_next;
            frame_start <= (cnt_next == '0) && (idx_next == '0);
            if (commit) begin
                commit_pending <= 1'b0;
            end else if (load) begin
                commit_pending <= 1'b1;
            end
            if (load) begin
                pend_en <= en_in;
            end
            disp_en <= disp_en_next;
            an      <= an_next;
            seg     <= seg_next;
            dp      <= dp_next;
        end
    end

    // Glyph and decimal-point data registers; only ever visible through the enables
    always_ff @(posedge clk) begin
        if (load) begin
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
        end
        disp_digits <= disp_digits_next;
        disp_dp     <= disp_dp_next;
    end

endmodule
